// File: rtl/adc_frame_aligner.sv
// FCO-based frame aligner in the DCO domain, ahead of the CDC FIFO.
// Deserialises DDR lanes into frames, hunts the FCO pattern over all bit offsets, locks with hysteresis.
//
// state   | meaning
// FILL    | history not yet full, evals ignored
// SEARCH  | testing the current offset, slip on mismatch
// LOCKED  | offset confirmed, aligned frames emitted
module adc_frame_aligner #(
    parameter int                    LANES        = 8,
    parameter int                    FRAME_BITS   = 16,
    parameter logic [FRAME_BITS-1:0] FCO_PATTERN  = 16'hFF00,
    parameter int                    LOCK_COUNT   = 4,
    parameter int                    UNLOCK_COUNT = 3,
    localparam int                   OFF_W        = $clog2(FRAME_BITS)
) (
    input  logic                        dco_clk,
    input  logic                        rst,
    input  logic [LANES-1:0]            lane_rise,
    input  logic [LANES-1:0]            lane_fall,
    input  logic                        fco_rise,
    input  logic                        fco_fall,
    input  logic                        in_valid,
    input  logic                        force_resync,
    output logic [LANES*FRAME_BITS-1:0] out_word,
    output logic                        out_valid,
    output logic                        aligned,
    output logic [OFF_W-1:0]            bit_offset,
    output logic [7:0]                  slip_count
);

    localparam int HIST_W = 2 * FRAME_BITS;
    localparam int PH_W   = $clog2(FRAME_BITS / 2);
    localparam int FILL_W = $clog2(FRAME_BITS);
    localparam int CNT_W  = 4;

    localparam logic [PH_W-1:0]   PH_LAST    = PH_W'(FRAME_BITS / 2 - 1);
    localparam logic [FILL_W-1:0] FILL_LAST  = FILL_W'(FRAME_BITS - 1);
    localparam logic [OFF_W-1:0]  OFF_LAST   = OFF_W'(FRAME_BITS - 1);
    localparam logic [CNT_W-1:0]  LOCK_LAST  = CNT_W'(LOCK_COUNT - 1);
    localparam logic [CNT_W-1:0]  UNLOCK_LAST = CNT_W'(UNLOCK_COUNT - 1);

    typedef enum logic [1:0] {
        S_FILL   = 2'd0,
        S_SEARCH = 2'd1,
        S_LOCKED = 2'd2
    } state_t;

    state_t state, state_nx;

    logic [LANES-1:0][HIST_W-1:0] lane_hist, lane_hist_nx;
    logic [HIST_W-1:0]            fco_hist, fco_hist_nx;
    logic [FRAME_BITS-1:0]        fco_win;
    logic [LANES*FRAME_BITS-1:0]  win_word;

    logic [PH_W-1:0]   phase;
    logic [FILL_W-1:0] fill_cnt;
    logic [OFF_W-1:0]  offset, offset_nx;
    logic [CNT_W-1:0]  match_cnt, match_nx;
    logic [CNT_W-1:0]  miss_cnt, miss_nx;
    logic [7:0]        slip_nx;
    logic              valid_nx;
    logic              load_word;
    logic              eval;
    logic              eval_match;

    // Evaluation looks at the history including this cycle's pair, so the window comes from the next-state value.
    always_comb begin
        lane_hist_nx = '0;
        win_word     = '0;
        for (int k = 0; k < LANES; k++) begin
            lane_hist_nx[k] = (lane_hist[k] << 2) | HIST_W'({lane_rise[k], lane_fall[k]});
            win_word[k*FRAME_BITS +: FRAME_BITS] = lane_hist_nx[k][offset +: FRAME_BITS];
        end
    end

    assign fco_hist_nx = (fco_hist << 2) | HIST_W'({fco_rise, fco_fall});
    assign fco_win     = fco_hist_nx[offset +: FRAME_BITS];
    assign eval        = in_valid && (phase == PH_LAST);
    assign eval_match  = (fco_win == FCO_PATTERN);

    assign aligned    = (state == S_LOCKED);
    assign bit_offset = offset;

    always_ff @(posedge dco_clk or posedge rst) begin
        if (rst) begin
            lane_hist <= '0;
            fco_hist  <= '0;
            phase     <= '0;
            fill_cnt  <= '0;
            out_word  <= '0;
        end else begin
            if (in_valid) begin
                lane_hist <= lane_hist_nx;
                fco_hist  <= fco_hist_nx;
                phase     <= (phase == PH_LAST) ? '0 : phase + 1'b1;
                if (state == S_FILL) begin
                    fill_cnt <= fill_cnt + 1'b1;
                end
            end
            if (load_word) begin
                out_word <= win_word;
            end
        end
    end

    always_ff @(posedge dco_clk or posedge rst) begin
        if (rst) begin
            state      <= S_FILL;
            offset     <= '0;
            match_cnt  <= '0;
            miss_cnt   <= '0;
            slip_count <= '0;
            out_valid  <= 1'b0;
        end else begin
            state      <= state_nx;
            offset     <= offset_nx;
            match_cnt  <= match_nx;
            miss_cnt   <= miss_nx;
            slip_count <= slip_nx;
            out_valid  <= valid_nx;
        end
    end

    // force_resync outranks a coincident eval, which is simply dropped.
    always_comb begin
        state_nx  = state;
        offset_nx = offset;
        match_nx  = match_cnt;
        miss_nx   = miss_cnt;
        slip_nx   = slip_count;
        valid_nx  = 1'b0;
        load_word = 1'b0;
        case (state)
            S_FILL: begin
                if (in_valid && (fill_cnt == FILL_LAST)) begin
                    state_nx = S_SEARCH;
                end
            end
            S_SEARCH: begin
                if (force_resync) begin
                    match_nx = '0;
                    miss_nx  = '0;
                end else if (eval) begin
                    if (eval_match) begin
                        if (match_cnt == LOCK_LAST) begin
                            state_nx  = S_LOCKED;
                            match_nx  = '0;
                            miss_nx   = '0;
                            valid_nx  = 1'b1;
                            load_word = 1'b1;
                        end else begin
                            match_nx = match_cnt + 1'b1;
                        end
                    end else begin
                        offset_nx = (offset == OFF_LAST) ? '0 : offset + 1'b1;
                        match_nx  = '0;
                        if (slip_count != 8'hFF) begin
                            slip_nx = slip_count + 8'd1;
                        end
                    end
                end
            end
            S_LOCKED: begin
                if (force_resync) begin
                    state_nx = S_SEARCH;
                    match_nx = '0;
                    miss_nx  = '0;
                end else if (eval) begin
                    if (eval_match) begin
                        miss_nx   = '0;
                        valid_nx  = 1'b1;
                        load_word = 1'b1;
                    end else if (miss_cnt == UNLOCK_LAST) begin
                        state_nx = S_SEARCH;
                        match_nx = '0;
                        miss_nx  = '0;
                    end else begin
                        miss_nx   = miss_cnt + 1'b1;
                        valid_nx  = 1'b1;
                        load_word = 1'b1;
                    end
                end
            end
            default: begin
                state_nx = S_FILL;
            end
        endcase
    end

endmodule

// File: tb/tb_adc_frame_aligner.sv
// Directed bench for adc_frame_aligner: skewed lane/FCO streams, lock, hysteresis, gaps, resync, reset.
module tb_adc_frame_aligner;
    localparam int LANES = 8;
    localparam int F     = 16;

    logic             dco_clk = 1'b0;
    logic             rst;
    logic [LANES-1:0] lane_rise, lane_fall;
    logic             fco_rise, fco_fall, in_valid, force_resync;
    logic [LANES*F-1:0] out_word;
    logic             out_valid, aligned;
    logic [3:0]       bit_offset;
    logic [7:0]       slip_count;

    int tests = 0;
    int fails = 0;
    int skew = 0;
    int nbits = 0;
    int vcnt = 0;
    int corrupt_lo = 0;
    int corrupt_hi = 0;
    bit fco_zero = 1'b0;
    logic [LANES*F-1:0] exp_word;

    adc_frame_aligner #(
        .LANES(LANES), .FRAME_BITS(F), .FCO_PATTERN(16'hFF00),
        .LOCK_COUNT(4), .UNLOCK_COUNT(3)
    ) dut (
        .dco_clk(dco_clk), .rst(rst), .lane_rise(lane_rise), .lane_fall(lane_fall),
        .fco_rise(fco_rise), .fco_fall(fco_fall), .in_valid(in_valid), .force_resync(force_resync),
        .out_word(out_word), .out_valid(out_valid), .aligned(aligned),
        .bit_offset(bit_offset), .slip_count(slip_count)
    );

    always #5 dco_clk = ~dco_clk;

    // Stream position pos = bit number + skew; lane index LANES selects the FCO.
    function automatic logic gen_bit(int lane, int pos);
        logic [15:0] w;
        int idx, frame;
        idx   = pos % 16;
        frame = pos / 16;
        if (lane == LANES) begin
            w = 16'hFF00;
            if (fco_zero) w = 16'h0000;
            else if (frame >= corrupt_lo && frame < corrupt_hi) w = ~w;
        end else begin
            w = 16'hA500 + 16'(lane);
        end
        return w[15-idx];
    endfunction

    task automatic step(input logic v);
        in_valid = v;
        if (v) begin
            for (int k = 0; k < LANES; k++) begin
                lane_rise[k] = gen_bit(k, nbits + skew);
                lane_fall[k] = gen_bit(k, nbits + skew + 1);
            end
            fco_rise = gen_bit(LANES, nbits + skew);
            fco_fall = gen_bit(LANES, nbits + skew + 1);
            nbits += 2;
            vcnt++;
        end else begin
            lane_rise = 8'($urandom);
            lane_fall = 8'($urandom);
            fco_rise  = 1'($urandom);
            fco_fall  = 1'($urandom);
        end
        @(posedge dco_clk);
        #1;
    endtask

    task automatic reset_dut;
        rst = 1'b1;
        nbits = 0;
        vcnt = 0;
        @(posedge dco_clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset;
        #1;
        tests++; if (aligned !== 1'b0 || out_valid !== 1'b0) begin fails++; $display("FAIL reset_flags: aligned=%0b out_valid=%0b expected 0/0", aligned, out_valid); end
        tests++; if (out_word !== '0) begin fails++; $display("FAIL reset_word: got %h expected 0", out_word); end
        tests++; if (bit_offset !== 4'd0 || slip_count !== 8'd0) begin fails++; $display("FAIL reset_counts: offset=%0d slip=%0d expected 0/0", bit_offset, slip_count); end
        @(posedge dco_clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_lock_skew5;
        int strobes;
        strobes = 0;
        skew = 5;
        for (int i = 1; i <= 88; i++) begin
            step(1'b1);
            if (i < 88 && out_valid === 1'b1) strobes++;
            if (i == 87) begin
                tests++; if (aligned !== 1'b0) begin fails++; $display("FAIL s5_prelock: aligned=%0b expected 0", aligned); end
            end
        end
        tests++; if (strobes != 0) begin fails++; $display("FAIL s5_search_strobes: got %0d expected 0", strobes); end
        tests++; if (aligned !== 1'b1 || out_valid !== 1'b1) begin fails++; $display("FAIL s5_lock: aligned=%0b out_valid=%0b expected 1/1", aligned, out_valid); end
        tests++; if (bit_offset !== 4'd5 || slip_count !== 8'd5) begin fails++; $display("FAIL s5_offset: offset=%0d slip=%0d expected 5/5", bit_offset, slip_count); end
        tests++; if (out_word !== exp_word) begin fails++; $display("FAIL s5_word: got %h expected %h", out_word, exp_word); end
        for (int i = 1; i <= 24; i++) begin
            step(1'b1);
            if (i == 1) begin
                tests++; if (out_valid !== 1'b0 || out_word !== exp_word) begin fails++; $display("FAIL s5_hold: out_valid=%0b word=%h expected 0/%h", out_valid, out_word, exp_word); end
            end
            if (i % 8 == 0) begin
                tests++; if (out_valid !== 1'b1 || out_word !== exp_word) begin fails++; $display("FAIL s5_stream: out_valid=%0b word=%h expected 1/%h", out_valid, out_word, exp_word); end
            end
        end
    endtask

    task automatic test_hysteresis;
        corrupt_lo = nbits / 16;
        corrupt_hi = corrupt_lo + 2;
        for (int i = 1; i <= 16; i++) begin
            step(1'b1);
            if (i % 8 == 0) begin
                tests++; if (aligned !== 1'b1 || out_valid !== 1'b1) begin fails++; $display("FAIL hyst2_keep: aligned=%0b out_valid=%0b expected 1/1", aligned, out_valid); end
            end
        end
        corrupt_lo = 0; corrupt_hi = 0;
        for (int i = 1; i <= 8; i++) step(1'b1);
        tests++; if (aligned !== 1'b1 || out_valid !== 1'b1) begin fails++; $display("FAIL hyst_clean: aligned=%0b out_valid=%0b expected 1/1", aligned, out_valid); end
        corrupt_lo = nbits / 16;
        corrupt_hi = corrupt_lo + 3;
        for (int i = 1; i <= 24; i++) begin
            step(1'b1);
            if (i == 8 || i == 16) begin
                tests++; if (aligned !== 1'b1 || out_valid !== 1'b1) begin fails++; $display("FAIL hyst3_keep: aligned=%0b out_valid=%0b expected 1/1", aligned, out_valid); end
            end
        end
        tests++; if (aligned !== 1'b0 || out_valid !== 1'b0 || bit_offset !== 4'd5) begin fails++; $display("FAIL hyst3_drop: aligned=%0b out_valid=%0b offset=%0d expected 0/0/5", aligned, out_valid, bit_offset); end
        corrupt_lo = 0; corrupt_hi = 0;
        for (int i = 1; i <= 32; i++) begin
            step(1'b1);
            if (i == 24) begin
                tests++; if (aligned !== 1'b0) begin fails++; $display("FAIL hyst_prerelock: aligned=%0b expected 0", aligned); end
            end
        end
        tests++; if (aligned !== 1'b1 || slip_count !== 8'd5 || bit_offset !== 4'd5) begin fails++; $display("FAIL hyst_relock: aligned=%0b slip=%0d offset=%0d expected 1/5/5", aligned, slip_count, bit_offset); end
    endtask

    task automatic test_skew_shift;
        skew = 8;
        for (int i = 1; i <= 24; i++) begin
            step(1'b1);
            if (i == 16) begin
                tests++; if (aligned !== 1'b1) begin fails++; $display("FAIL shift_keep: aligned=%0b expected 1", aligned); end
            end
        end
        tests++; if (aligned !== 1'b0) begin fails++; $display("FAIL shift_unlock: aligned=%0b expected 0", aligned); end
        for (int i = 1; i <= 56; i++) begin
            step(1'b1);
            if (i == 48) begin
                tests++; if (aligned !== 1'b0 || bit_offset !== 4'd8) begin fails++; $display("FAIL shift_search: aligned=%0b offset=%0d expected 0/8", aligned, bit_offset); end
            end
        end
        tests++; if (aligned !== 1'b1 || bit_offset !== 4'd8 || slip_count !== 8'd8) begin fails++; $display("FAIL shift_relock: aligned=%0b offset=%0d slip=%0d expected 1/8/8", aligned, bit_offset, slip_count); end
        tests++; if (out_word !== exp_word) begin fails++; $display("FAIL shift_word: got %h expected %h", out_word, exp_word); end
    endtask

    task automatic test_gaps;
        int vsteps, strobes;
        logic v, exp_v;
        vsteps = 0; strobes = 0;
        for (int i = 0; i < 400 && vsteps < 48; i++) begin
            v = ($urandom_range(0, 99) >= 30);
            step(v);
            if (v) vsteps++;
            exp_v = v && (vcnt % 8 == 0);
            tests++; if (out_valid !== exp_v) begin fails++; $display("FAIL gap_valid: got %0b expected %0b at step %0d", out_valid, exp_v, i); end
            if (out_valid === 1'b1) begin
                strobes++;
                tests++; if (out_word !== exp_word) begin fails++; $display("FAIL gap_word: got %h expected %h", out_word, exp_word); end
            end
        end
        tests++; if (vsteps != 48) begin fails++; $display("FAIL gap_budget: got %0d valid cycles expected 48", vsteps); end
        tests++; if (strobes != 6 || aligned !== 1'b1) begin fails++; $display("FAIL gap_strobes: got %0d aligned=%0b expected 6/1", strobes, aligned); end
    endtask

    task automatic test_resync;
        for (int i = 0; i < 8 && (vcnt % 8) != 7; i++) step(1'b1);
        force_resync = 1'b1;
        step(1'b1);
        force_resync = 1'b0;
        tests++; if (aligned !== 1'b0 || out_valid !== 1'b0 || bit_offset !== 4'd8) begin fails++; $display("FAIL resync_drop: aligned=%0b out_valid=%0b offset=%0d expected 0/0/8", aligned, out_valid, bit_offset); end
        for (int i = 1; i <= 32; i++) begin
            step(1'b1);
            if (i == 24) begin
                tests++; if (aligned !== 1'b0) begin fails++; $display("FAIL resync_prelock: aligned=%0b expected 0", aligned); end
            end
        end
        tests++; if (aligned !== 1'b1 || out_valid !== 1'b1 || slip_count !== 8'd8) begin fails++; $display("FAIL resync_relock: aligned=%0b out_valid=%0b slip=%0d expected 1/1/8", aligned, out_valid, slip_count); end
    endtask

    task automatic test_reset_mid_lock;
        #2;
        rst = 1'b1;
        #1;
        tests++; if (aligned !== 1'b0 || out_valid !== 1'b0 || out_word !== '0) begin fails++; $display("FAIL midreset_out: aligned=%0b out_valid=%0b word=%h expected all 0", aligned, out_valid, out_word); end
        tests++; if (bit_offset !== 4'd0 || slip_count !== 8'd0) begin fails++; $display("FAIL midreset_counts: offset=%0d slip=%0d expected 0/0", bit_offset, slip_count); end
        skew = 15;
        nbits = 0;
        vcnt = 0;
        @(posedge dco_clk);
        #1;
        rst = 1'b0;
        for (int i = 1; i <= 168; i++) begin
            step(1'b1);
            if (i == 167) begin
                tests++; if (aligned !== 1'b0) begin fails++; $display("FAIL s15_prelock: aligned=%0b expected 0", aligned); end
            end
        end
        tests++; if (aligned !== 1'b1 || bit_offset !== 4'd15 || slip_count !== 8'd15) begin fails++; $display("FAIL s15_lock: aligned=%0b offset=%0d slip=%0d expected 1/15/15", aligned, bit_offset, slip_count); end
        tests++; if (out_word !== exp_word) begin fails++; $display("FAIL s15_word: got %h expected %h", out_word, exp_word); end
    endtask

    task automatic test_slip_saturate;
        fco_zero = 1'b1;
        skew = 0;
        reset_dut();
        for (int i = 1; i <= 2096; i++) begin
            step(1'b1);
            if (i == 2048) begin
                tests++; if (slip_count !== 8'd254) begin fails++; $display("FAIL sat_before: slip=%0d expected 254", slip_count); end
            end
        end
        tests++; if (slip_count !== 8'd255 || bit_offset !== 4'd4 || aligned !== 1'b0) begin fails++; $display("FAIL sat_final: slip=%0d offset=%0d aligned=%0b expected 255/4/0", slip_count, bit_offset, aligned); end
        fco_zero = 1'b0;
    endtask

    task automatic test_skew16;
        skew = 16;
        reset_dut();
        for (int i = 1; i <= 48; i++) begin
            step(1'b1);
            if (i == 47) begin
                tests++; if (aligned !== 1'b0) begin fails++; $display("FAIL s16_prelock: aligned=%0b expected 0", aligned); end
            end
        end
        tests++; if (aligned !== 1'b1 || bit_offset !== 4'd0 || slip_count !== 8'd0) begin fails++; $display("FAIL s16_lock: aligned=%0b offset=%0d slip=%0d expected 1/0/0", aligned, bit_offset, slip_count); end
        tests++; if (out_word !== exp_word) begin fails++; $display("FAIL s16_word: got %h expected %h", out_word, exp_word); end
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        force_resync = 1'b0;
        lane_rise = '0;
        lane_fall = '0;
        fco_rise = 1'b0;
        fco_fall = 1'b0;
        for (int k = 0; k < LANES; k++) exp_word[k*F +: F] = 16'hA500 + 16'(k);
        test_reset();
        test_lock_skew5();
        test_hysteresis();
        test_skew_shift();
        test_gaps();
        test_resync();
        test_reset_mid_lock();
        test_slip_saturate();
        test_skew16();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
